shift_arbiter: RTL and testbench

Shares a single 32-bit combinational barrel shifter between two requesters (e.g. the ALU shift path and a secondary unit such as a multiply/divide sequencer). Round-robin arbitration selects one request per cycle. The shift is computed in the grant cycle and the result is captured in a one-entry output register. Results return on a single tagged response channel with valid/ready backpressure.

---
 rtl/shift_pkg.sv | 19 +
 rtl/shift_arbiter_if.sv | 46 ++++
 rtl/shift_arbiter_shifter.sv | 21 ++
 rtl/shift_arbiter.sv | 74 +++++++
 tb/tb_shift_arbiter.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared types and widths for the shared barrel-shifter arbiter.
package shift_pkg;

  localparam int DATA_W = 32;
  localparam int SH_W   = 5;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [SH_W-1:0]   amt;
    logic              right;
    logic              arith;
  } shift_req_t;

  typedef struct packed {
    logic              id;
    logic [DATA_W-1:0] result;
  } shift_rsp_t;

endpackage

// File: rtl/shift_arbiter_if.sv
// Two request channels and one tagged response channel.
interface shift_arbiter_if;
  import shift_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_data;
  logic [SH_W-1:0]   req0_amt;
  logic              req0_right;
  logic              req0_arith;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_data;
  logic [SH_W-1:0]   req1_amt;
  logic              req1_right;
  logic              req1_arith;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_result;

  modport master (
    output req0_valid, req0_data, req0_amt,
    output req0_right, req0_arith,
    input  req0_ready,
    output req1_valid, req1_data, req1_amt,
    output req1_right, req1_arith,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_result,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_data, req0_amt,
    input  req0_right, req0_arith,
    output req0_ready,
    input  req1_valid, req1_data, req1_amt,
    input  req1_right, req1_arith,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_result,
    input  rsp_ready
  );

endinterface

// File: rtl/shift_arbiter_shifter.sv
// Combinational 32-bit barrel shifter: left, logical right, arith right.
module shift_arbiter_shifter
  import shift_pkg::*;
(
  input  shift_req_t        req,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = req.data;
    unique case (1'b1)
      !req.right:
        result = req.data << req.amt;
      req.right && !req.arith:
        result = req.data >> req.amt;
      default:
        result = unsigned'($signed(req.data) >>> req.amt);
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin share of one barrel shifter between two requesters,
// with a one-entry tagged result register.
module shift_arbiter
  import shift_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  shift_arbiter_if.slave bus
);

  logic              last;
  logic              valid_q;
  shift_rsp_t        rsp_q;
  logic              slot_free;
  logic              grant0;
  logic              grant1;
  logic              rdy0;
  logic              rdy1;
  logic              accept;
  shift_req_t        sel_req;
  logic [DATA_W-1:0] sh_result;

  // rst_n gates ready so nothing is offered while held in reset
  assign slot_free = rst_n & (~valid_q | bus.rsp_ready);

  assign grant0 = bus.req0_valid
                & (~bus.req1_valid | last);
  assign grant1 = bus.req1_valid & ~grant0;

  assign rdy0   = grant0 & slot_free;
  assign rdy1   = grant1 & slot_free;
  assign accept = rdy0 | rdy1;

  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;

  always_comb begin
    sel_req.data  = bus.req0_data;
    sel_req.amt   = bus.req0_amt;
    sel_req.right = bus.req0_right;
    sel_req.arith = bus.req0_arith;
    if (grant1) begin
      sel_req.data  = bus.req1_data;
      sel_req.amt   = bus.req1_amt;
      sel_req.right = bus.req1_right;
      sel_req.arith = bus.req1_arith;
    end
  end

  shift_arbiter_shifter u_shifter (
    .req    (sel_req),
    .result (sh_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      rsp_q   <= '0;
      last    <= 1'b1;
    end else if (accept) begin
      valid_q      <= 1'b1;
      rsp_q.id     <= grant1;
      rsp_q.result <= sh_result;
      last         <= grant1;
    end else if (bus.rsp_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.rsp_valid  = valid_q;
  assign bus.rsp_id     = rsp_q.id;
  assign bus.rsp_result = rsp_q.result;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed and random checks of shift_arbiter against a behavioural model.
module tb_shift_arbiter;
  import shift_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shift_arbiter_if bus ();

  shift_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  bit          m_valid;
  bit          m_id;
  bit          m_last;
  logic [31:0] m_res;
  bit          acc0;
  bit          acc1;

  function automatic logic [31:0] ref_shift(
    logic [31:0] d, int amt, bit right, bit arith);
    longint p = 1;
    longint v;
    for (int k = 0; k < amt; k++) p = p * 2;
    if (!right) return 32'(longint'(d) * p);
    if (!arith || !d[31]) return 32'(longint'(d) / p);
    v = longint'(d) - 64'sh1_0000_0000;
    return 32'((v - (p - 1)) / p);
  endfunction

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_id    = 1'b0;
    m_res   = '0;
    m_last  = 1'b1;
  endtask

  task automatic set_req(int i, bit v, logic [31:0] d,
                         logic [4:0] a, bit r, bit ar);
    if (i == 0) begin
      bus.req0_valid = v;
      bus.req0_data  = d;
      bus.req0_amt   = a;
      bus.req0_right = r;
      bus.req0_arith = ar;
    end else begin
      bus.req1_valid = v;
      bus.req1_data  = d;
      bus.req1_amt   = a;
      bus.req1_right = r;
      bus.req1_arith = ar;
    end
  endtask

  task automatic rand_req(int i);
    set_req(i, 1'($urandom_range(0, 1)), $urandom,
            5'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // Called just after a negedge with inputs settled.
  task automatic cycle();
    bit s, g0, g1, a0, a1;
    #1;
    check("rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
    check("rsp_id", 32'(bus.rsp_id), 32'(m_id));
    check("rsp_result", bus.rsp_result, m_res);
    s  = rst_n && (!m_valid || bus.rsp_ready);
    g0 = bus.req0_valid && (!bus.req1_valid || m_last);
    g1 = bus.req1_valid && !g0;
    a0 = g0 && s;
    a1 = g1 && s;
    check("req0_ready", 32'(bus.req0_ready), 32'(a0));
    check("req1_ready", 32'(bus.req1_ready), 32'(a1));
    @(posedge clk);
    if (rst_n) begin
      if (a0 || a1) begin
        m_valid = 1'b1;
        m_id    = a1;
        m_last  = a1;
        m_res   = a1 ?
          ref_shift(bus.req1_data, int'(bus.req1_amt),
                    bus.req1_right, bus.req1_arith) :
          ref_shift(bus.req0_data, int'(bus.req0_amt),
                    bus.req0_right, bus.req0_arith);
      end else if (bus.rsp_ready) begin
        m_valid = 1'b0;
      end
    end
    acc0 = a0;
    acc1 = a1;
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    bus.rsp_ready = 1'b1;
    set_req(0, 1, 32'h1234_5678, 5'd3, 0, 0);
    set_req(1, 1, 32'h8765_4321, 5'd7, 1, 1);

    // held in reset with both requesters valid
    @(negedge clk);
    cycle();
    cycle();

    rst_n = 1'b1;
    set_req(1, 0, 0, 0, 0, 0);
    set_req(0, 1, 32'h0000_00F0, 5'd4, 0, 0);
    cycle();
    set_req(0, 0, 0, 0, 0, 0);
    check("left_const", bus.rsp_result, 32'h0000_0F00);
    check("left_id", 32'(bus.rsp_id), 32'd0);

    set_req(1, 1, 32'h8000_0000, 5'd31, 1, 1);
    cycle();
    check("sra31", bus.rsp_result, 32'hFFFF_FFFF);
    check("sra31_id", 32'(bus.rsp_id), 32'd1);
    set_req(1, 1, 32'h8000_0000, 5'd31, 1, 0);
    cycle();
    check("srl31", bus.rsp_result, 32'h0000_0001);
    set_req(1, 1, 32'h8000_0000, 5'd0, 1, 1);
    cycle();
    check("sra0", bus.rsp_result, 32'h8000_0000);
    set_req(1, 0, 0, 0, 0, 0);

    // contention: strict alternation, one result per cycle
    for (int k = 0; k < 4; k++) begin
      rand_req(0);
      rand_req(1);
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      cycle();
      check("fair_id", 32'(bus.rsp_id), 32'(k % 2));
      check("fair_valid", 32'(bus.rsp_valid), 32'd1);
    end

    set_req(1, 0, 0, 0, 0, 0);
    set_req(0, 1, 32'h1, 5'd1, 0, 0);
    cycle();
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 1, 32'hF000_000F, 5'd8, 1, 1);
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("stall_result", bus.rsp_result, 32'h0000_0002);
      check("stall_rdy1", 32'(bus.req1_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("release_rdy1", 32'(bus.req1_ready), 32'd1);
    cycle();
    set_req(1, 0, 0, 0, 0, 0);
    check("release_id", 32'(bus.rsp_id), 32'd1);
    check("release_res", bus.rsp_result, 32'hFFF0_0000);

    for (int n = 0; n < 400; n++) begin
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      if (acc0 || !bus.req0_valid) rand_req(0);
      if (acc1 || !bus.req1_valid) rand_req(1);
      cycle();
    end

    // async reset in the middle of a stall
    set_req(1, 0, 0, 0, 0, 0);
    set_req(0, 1, 32'hA5A5_5A5A, 5'd5, 1, 0);
    bus.rsp_ready = 1'b1;
    cycle();
    set_req(0, 0, 0, 0, 0, 0);
    bus.rsp_ready = 1'b0;
    cycle();
    check("prestall_valid", 32'(bus.rsp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", 32'(bus.rsp_valid), 32'd0);
    check("async_result", bus.rsp_result, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 1, 32'h0000_0003, 5'd2, 0, 0);
    set_req(1, 1, 32'h0000_0010, 5'd4, 1, 0);
    bus.rsp_ready = 1'b1;
    cycle();
    cycle();
    check("post_rst_id", 32'(bus.rsp_id), 32'd1);
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
